ne_unit: RTL and testbench

Nonlinear-energy (Teager) operator stage that sits directly upstream of the windowed accumulator in the feature-extraction path. It takes a stream of signed samples and computes ψ[n] = x[n]² − x[n−1]·x[n+1] for each interior sample. The result is emitted as a signed word together with an active-low enable pulse, in exactly the format the accumulator's `din`/`en` inputs consume. It is two pipeline stages deep and has no backpressure, because the accumulator never stalls.

---
 rtl/ne_unit.sv | 104 ++++++++++
 tb/tb_ne_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ne_unit.sv
// Teager nonlinear-energy stage: psi[n] = x[n]^2 - x[n-1]*x[n+1], two pipeline stages.
// Define NE_ABS_EN to emit |psi| instead of the signed difference.
module ne_unit #(
   parameter int unsigned InputWidth  = 16,
   parameter int unsigned OutputWidth = 32
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_clr,
   input  logic signed [InputWidth-1:0]  i_din,
   input  logic                          i_din_valid,
   output logic signed [OutputWidth-1:0] o_dout,
   output logic                          o_dout_en_n,
   output logic                          o_primed
);

   typedef enum logic [1:0] {StEmpty, StOne, StRun} state_e;

   state_e                         r_state, w_state_next;
   logic signed [InputWidth-1:0]   r_x1, r_x2;
   logic signed [OutputWidth-1:0]  r_sq, r_cr;
   logic                           r_p_vld;
   logic                           w_fire;
   logic signed [OutputWidth-1:0]  w_x1_ext, w_x2_ext, w_din_ext;
   logic signed [OutputWidth-1:0]  w_diff, w_result;

   always_comb begin
      w_state_next = r_state;
      if (i_din_valid) begin
         case (r_state)
            StEmpty: w_state_next = StOne;
            StOne:   w_state_next = StRun;
            default: w_state_next = StRun;
         endcase
      end
   end

   assign w_fire   = i_din_valid && (r_state == StRun);
   assign o_primed = (r_state == StRun);

   // Sign-extend before multiplying so the full 2w-bit product is kept.
   assign w_x1_ext  = {{InputWidth{r_x1[InputWidth-1]}}, r_x1};
   assign w_x2_ext  = {{InputWidth{r_x2[InputWidth-1]}}, r_x2};
   assign w_din_ext = {{InputWidth{i_din[InputWidth-1]}}, i_din};
   assign w_diff    = r_sq - r_cr;

`ifdef NE_ABS_EN
   assign w_result = w_diff[OutputWidth-1] ? -w_diff : w_diff;
`else
   assign w_result = w_diff;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StEmpty;
         r_x1    <= '0;
         r_x2    <= '0;
      end else if (i_clr) begin
         r_state <= StEmpty;
         r_x1    <= '0;
         r_x2    <= '0;
      end else begin
         r_state <= w_state_next;
         if (i_din_valid) begin
            r_x2 <= r_x1;
            r_x1 <= i_din;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sq    <= '0;
         r_cr    <= '0;
         r_p_vld <= 1'b0;
      end else if (i_clr) begin
         r_sq    <= '0;
         r_cr    <= '0;
         r_p_vld <= 1'b0;
      end else begin
         r_p_vld <= w_fire;
         if (w_fire) begin
            r_sq <= w_x1_ext * w_x1_ext;
            r_cr <= w_x2_ext * w_din_ext;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_dout      <= '0;
         o_dout_en_n <= 1'b1;
      end else if (i_clr) begin
         o_dout      <= '0;
         o_dout_en_n <= 1'b1;
      end else if (r_p_vld) begin
         o_dout      <= w_result;
         o_dout_en_n <= 1'b0;
      end else begin
         o_dout_en_n <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ne_unit.sv
// Self-checking bench for ne_unit: per-cycle compare against a sample-history model,
// plus directed literal expectations.
module tb_ne_unit;

   localparam int W  = 16;
   localparam int OW = 32;

   logic                 clk       = 1'b0;
   logic                 rst_n     = 1'b1;
   logic                 clr       = 1'b0;
   logic                 din_valid = 1'b0;
   logic signed [W-1:0]  din       = '0;
   logic signed [OW-1:0] dout;
   logic                 dout_en_n;
   logic                 primed;

   int checks = 0;
   int errors = 0;

   ne_unit #(
      .InputWidth (W),
      .OutputWidth(OW)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_clr      (clr),
      .i_din      (din),
      .i_din_valid(din_valid),
      .o_dout     (dout),
      .o_dout_en_n(dout_en_n),
      .o_primed   (primed)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic longint teager(input longint prev, input longint cen, input longint nxt);
      longint p;
      p = cen * cen - prev * nxt;
`ifdef NE_ABS_EN
      if (p < 0) p = -p;
`endif
      return p;
   endfunction

   // Model: keep the last two accepted samples and a list of results with the edge
   // on which each must appear on the output.
   typedef struct {
      int     due;
      longint val;
   } res_t;

   res_t   pend[$];
   longint m_h1    = 0;
   longint m_h2    = 0;
   int     m_cnt   = 0;
   int     m_edge  = 0;
   longint m_dout  = 0;
   logic   m_en_n  = 1'b1;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || clr) begin
         if (rst_n) m_edge++;
         m_cnt  = 0;
         m_h1   = 0;
         m_h2   = 0;
         pend.delete();
         m_dout = 0;
         m_en_n = 1'b1;
      end else begin
         m_edge++;
         m_en_n = 1'b1;
         if (pend.size() > 0 && pend[0].due == m_edge) begin
            m_dout = pend[0].val;
            m_en_n = 1'b0;
            void'(pend.pop_front());
         end
         if (din_valid) begin
            if (m_cnt >= 2) pend.push_back('{m_edge + 1, teager(m_h2, m_h1, longint'(din))});
            m_h2 = m_h1;
            m_h1 = longint'(din);
            if (m_cnt < 2) m_cnt++;
         end
      end
   end

   longint obs[$];

   initial forever begin
      @(negedge clk);
      check("dout", longint'(dout), m_dout);
      check("dout_en_n", longint'(dout_en_n), longint'(m_en_n));
      check("primed", longint'(primed), (m_cnt >= 2) ? 1 : 0);
      if (!dout_en_n) obs.push_back(longint'(dout));
   end

   task automatic drive(input logic v, input int d, input logic c);
      @(negedge clk);
      #1;
      din_valid = v;
      din       = W'(d);
      clr       = c;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 1'b0);
   endtask

   int  base;
   int  rnd;
`ifdef NE_ABS_EN
   localparam longint Second = 31;
`else
   localparam longint Second = -31;
`endif

   initial begin
      #2 rst_n = 1'b0;
      for (int i = 0; i < 6; i++) drive(i[0], 9 + i, 1'b0);
      check("rst_dout", longint'(dout), 0);
      check("rst_en_n", longint'(dout_en_n), 1);
      check("rst_primed", longint'(primed), 0);
      @(negedge clk);
      #1;
      rst_n     = 1'b1;
      din_valid = 1'b0;

      // Two samples only: primed, no strobe
      base = obs.size();
      drive(1'b1, 3, 1'b0);
      drive(1'b1, 5, 1'b0);
      drive(1'b0, 0, 1'b0);
      check("primed_after_2", longint'(primed), 1);
      idle(2);
      check("no_strobe_2", obs.size() - base, 0);

      // Contiguous 3,5,2,7
      drive(1'b0, 0, 1'b1);
      base = obs.size();
      drive(1'b1, 3, 1'b0);
      drive(1'b1, 5, 1'b0);
      drive(1'b1, 2, 1'b0);
      drive(1'b1, 7, 1'b0);
      drive(1'b0, 0, 1'b0);
      check("lat_dout_19", longint'(dout), 19);
      check("lat_en_n", longint'(dout_en_n), 0);
      drive(1'b0, 0, 1'b0);
      check("second_dout", longint'(dout), Second);
      check("second_en_n", longint'(dout_en_n), 0);
      idle(3);
      check("count_3527", obs.size() - base, 2);

      // Extremes
      drive(1'b0, 0, 1'b1);
      base = obs.size();
      drive(1'b1, -32768, 1'b0);
      drive(1'b1, -32768, 1'b0);
      drive(1'b1, 32767, 1'b0);
      drive(1'b1, -32768, 1'b0);
      drive(1'b1, -32768, 1'b0);
      drive(1'b1, -32768, 1'b0);
      idle(3);
      check("ext_count", obs.size() - base, 4);
      if (obs.size() - base == 4) begin
         check("ext_max", obs[base], 2147450880);
         check("ext_zero", obs[base+3], 0);
      end

      // Gapped samples
      drive(1'b0, 0, 1'b1);
      base = obs.size();
      drive(1'b1, 3, 1'b0);
      idle(4);
      drive(1'b1, 5, 1'b0);
      idle(4);
      drive(1'b1, 2, 1'b0);
      drive(1'b0, 0, 1'b0);
      drive(1'b0, 0, 1'b0);
      check("gap_dout", longint'(dout), 19);
      check("gap_en_n", longint'(dout_en_n), 0);
      idle(4);
      check("gap_hold", longint'(dout), 19);
      check("gap_idle_en_n", longint'(dout_en_n), 1);
      check("gap_count", obs.size() - base, 1);

      // clr together with the third sample
      drive(1'b0, 0, 1'b1);
      base = obs.size();
      drive(1'b1, 3, 1'b0);
      drive(1'b1, 5, 1'b0);
      drive(1'b1, 2, 1'b1);
      idle(3);
      check("clr3_count", obs.size() - base, 0);
      check("clr3_primed", longint'(primed), 0);
      drive(1'b1, 4, 1'b0);
      drive(1'b1, 6, 1'b0);
      idle(2);
      check("clr3_refill", obs.size() - base, 0);
      drive(1'b1, 1, 1'b0);
      idle(3);
      check("clr3_next", obs.size() - base, 1);
      if (obs.size() - base == 1) check("clr3_val", obs[base], 32);

      // clr one cycle after the third sample kills the in-flight result
      drive(1'b0, 0, 1'b1);
      base = obs.size();
      drive(1'b1, 3, 1'b0);
      drive(1'b1, 5, 1'b0);
      drive(1'b1, 2, 1'b0);
      drive(1'b0, 0, 1'b1);
      idle(3);
      check("kill_count", obs.size() - base, 0);
      check("kill_dout", longint'(dout), 0);
      drive(1'b1, 2, 1'b0);
      drive(1'b1, 3, 1'b0);
      drive(1'b1, 4, 1'b0);
      idle(3);
      check("kill_next", obs.size() - base, 1);
      if (obs.size() - base == 1) check("kill_val", obs[base], 1);

      // 53 contiguous samples give 51 strobes
      drive(1'b0, 0, 1'b1);
      base = obs.size();
      for (int i = 0; i < 53; i++) begin
         rnd = int'($urandom_range(0, 65535));
         drive(1'b1, rnd, 1'b0);
      end
      idle(4);
      check("count_53", obs.size() - base, 51);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
